// File: rtl/neuron_mac.sv
// neuron_mac: sequential signed fixed-point MAC over INPUT_SIZE serialized activations.
// Optional ReLU activation is enabled by defining NEURON_MAC_RELU_EN.
module neuron_mac #(
  parameter int INPUT_SIZE = 8,
  parameter int Q_SIZE     = 16,
  parameter int FRAC_BITS  = 8,
  localparam int AW        = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [Q_SIZE-1:0] bias_in,
  output logic              busy,
  input  logic [Q_SIZE-1:0] serial_in,
  output logic              serializer_shift,
  output logic [AW-1:0]     weight_addr,
  input  logic [Q_SIZE-1:0] weight_in,
  output logic [Q_SIZE-1:0] result,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int ACC_W = 2*Q_SIZE + $clog2(INPUT_SIZE) + 1;
  localparam int PW    = 2*Q_SIZE;

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | shifting one activation per cycle, accumulating delayed products
  // LAST  | adding final product, registering saturated result
  // DONE  | result_valid high until result_ready
  typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} state_t;

  state_t state, state_next;

  logic [AW-1:0]           idx;
  logic signed [ACC_W-1:0] acc;
  logic [Q_SIZE-1:0]       x_q;
  logic                    p_vld;
  logic [Q_SIZE-1:0]       result_q;

  logic signed [PW-1:0]    x_ext, w_ext, prod;
  logic signed [ACC_W-1:0] acc_next, scaled, act;
  logic [Q_SIZE-1:0]       sat_val;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-Q_SIZE+1){1'b0}}, {(Q_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-Q_SIZE+1){1'b1}}, {(Q_SIZE-1){1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (idx == AW'(INPUT_SIZE-1)) state_next = LAST;
      LAST: state_next = DONE;
      DONE: if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign x_ext    = {{(PW-Q_SIZE){x_q[Q_SIZE-1]}}, x_q};
  assign w_ext    = {{(PW-Q_SIZE){weight_in[Q_SIZE-1]}}, weight_in};
  assign prod     = x_ext * w_ext;
  assign acc_next = p_vld ? acc + {{(ACC_W-PW){prod[PW-1]}}, prod} : acc;
  assign scaled   = acc_next >>> FRAC_BITS;

  always_comb begin
    act = scaled;
`ifdef NEURON_MAC_RELU_EN
    if (scaled[ACC_W-1]) act = '0;
`endif
    if (act > SAT_MAX)      sat_val = SAT_MAX[Q_SIZE-1:0];
    else if (act < SAT_MIN) sat_val = SAT_MIN[Q_SIZE-1:0];
    else                    sat_val = act[Q_SIZE-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      acc      <= '0;
      x_q      <= '0;
      p_vld    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx   <= '0;
          acc   <= {{(ACC_W-Q_SIZE){bias_in[Q_SIZE-1]}}, bias_in} <<< FRAC_BITS;
          p_vld <= 1'b0;
        end
        RUN: begin
          x_q   <= serial_in;
          p_vld <= 1'b1;
          acc   <= acc_next;
          idx   <= idx + 1'b1;
        end
        LAST: begin
          acc      <= acc_next;
          p_vld    <= 1'b0;
          result_q <= sat_val;
        end
        default: ;
      endcase
    end
  end

  assign busy             = (state != IDLE);
  assign serializer_shift = (state == RUN);
  assign weight_addr      = (state == RUN) ? idx : '0;
  assign result_valid     = (state == DONE);
  assign result           = result_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: directed and random neurons against an arithmetic model.
module tb_neuron_mac;
  localparam int N = 4;
  localparam int Q = 16;
  localparam int F = 8;

  logic          clk = 1'b0;
  logic          rst, start, load, result_ready;
  logic [Q-1:0]  bias_in, serial_in, weight_in, result;
  logic          busy, serializer_shift, result_valid;
  logic [1:0]    weight_addr;

  logic [Q-1:0]  sx [N];
  logic [Q-1:0]  wmem [N];
  logic [1:0]    ptr;
  longint        exp_q [$];
  int            total = 0, bad = 0;

  always #5 clk = ~clk;

  neuron_mac #(.INPUT_SIZE(N), .Q_SIZE(Q), .FRAC_BITS(F)) dut (
    .clk(clk), .rst(rst), .start(start), .bias_in(bias_in), .busy(busy),
    .serial_in(serial_in), .serializer_shift(serializer_shift),
    .weight_addr(weight_addr), .weight_in(weight_in), .result(result),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  // behavioural serializer and 1-cycle-latency weight memory
  assign serial_in = sx[ptr];
  always @(posedge clk) begin
    weight_in <= wmem[weight_addr];
    if (load) ptr <= 2'd0;
    else if (serializer_shift) ptr <= ptr + 2'd1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint model(input logic [Q-1:0] b);
    longint sum, v;
    sum = longint'($signed(b)) * (longint'(1) <<< F);
    for (int i = 0; i < N; i++)
      sum += longint'($signed(sx[i])) * longint'($signed(wmem[i]));
    v = sum >>> F;
`ifdef NEURON_MAC_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  // monitor: every accepted result is matched against the oldest expectation
  always @(negedge clk) begin
    #2;
    if (!rst && result_valid && result_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
      else chk("result", longint'($signed(result)), exp_q.pop_front());
    end
  end

  task automatic set_vec(input int x0, input int x1, input int x2, input int x3, input int w);
    sx[0] = Q'(x0); sx[1] = Q'(x1); sx[2] = Q'(x2); sx[3] = Q'(x3);
    for (int i = 0; i < N; i++) wmem[i] = Q'(w);
  endtask

  task automatic run(input logic [Q-1:0] b, input int hold);
    int n, shifts;
    logic [Q-1:0] held;
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0; start = 1'b1; bias_in = b;
    result_ready = (hold == 0);
    exp_q.push_back(model(b));
    @(negedge clk); start = 1'b0; bias_in = Q'($urandom);
    n = 1; shifts = 0;
    while (!result_valid && n < 40) begin
      if (serializer_shift) begin
        chk("weight_addr", longint'(weight_addr), shifts);
        shifts++;
      end
      @(negedge clk); n++;
    end
    chk("latency", n, N + 2);
    chk("shift_cycles", shifts, N);
    held = result;
    for (int k = 0; k < hold; k++) begin
      start = (k % 3 == 2);
      @(negedge clk);
      chk("hold_result", longint'(result), longint'(held));
      chk("hold_valid", longint'(result_valid), 1);
      chk("hold_busy", longint'(busy), 1);
      chk("hold_shift", longint'(serializer_shift), 0);
    end
    result_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("idle_after_ready", longint'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; load = 1'b0; result_ready = 1'b0; bias_in = '0;
    set_vec(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_shift", longint'(serializer_shift), 0);
    chk("rst_addr", longint'(weight_addr), 0);
    chk("rst_result", longint'(result), 0);
    chk("rst_valid", longint'(result_valid), 0);
    rst = 1'b0;

    set_vec(256, 256, 256, 256, 256);            run(16'd0, 0);
    set_vec(256, 512, 0, 0, 256);                run(16'd128, 0);
    set_vec(-256, -256, -256, -256, 256);        run(16'd0, 0);
    set_vec(32767, 32767, 32767, 32767, 32767);  run(16'd0, 0);
    set_vec(-32768, -32768, -32768, -32768, 32767); run(16'd0, 0);
    set_vec(256, 256, 256, 256, 256);            run(16'd0, 10);

    // reset during the second RUN cycle discards the partial sum
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0; start = 1'b1; bias_in = 16'd0; result_ready = 1'b1;
    exp_q.push_back(model(16'd0));
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk); rst = 1'b0;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_shift", longint'(serializer_shift), 0);
    chk("midrst_valid", longint'(result_valid), 0);
    run(16'd0, 0);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) != 0) begin
          sx[i] = Q'($urandom); wmem[i] = Q'($urandom);
        end else begin
          sx[i] = Q'($urandom_range(0, 2047) - 1024);
          wmem[i] = Q'($urandom_range(0, 2047) - 1024);
        end
      end
      run(Q'($urandom_range(0, 4095) - 2048), int'($urandom_range(0, 3)));
    end

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
